// File: rtl/data_mem_responder_if.sv
// Request/response bundle between a CPU data-memory initiator and its memory responder.
// Latency: none, this only groups wires; timing belongs to the modules on either end.
// Backpressure: req_ready stalls the request side, resp_ready stalls the response side.
// Ports: req_valid/req_write/req_addr/req_wdata/req_ready carry one word request;
//        resp_valid/resp_ready/resp_rdata/resp_err carry its single response.
interface data_mem_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-wide data memory that answers one load/store at a time with a fixed access delay.
// Latency: request accepted at edge E gives resp_valid after edge E+WAIT_CYCLES+1.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
// Ports: clk, rst_n (async active-low); bus (slave side of data_mem_if) carries the
//        request handshake (valid/write/addr/wdata/ready) and response handshake
//        (valid/ready/rdata/err).
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic      clk,
  input logic      rst_n,
  data_mem_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Storage is deliberately left out of reset: contents survive rst_n.
  logic [31:0] mem [DEPTH_WORDS];

  logic             access_err;
  logic [IDX_W-1:0] word_idx;
  logic             mem_we;

  // Full 30-bit word index is range-checked; only the low bits address the array.
  assign word_idx   = addr_q[IDX_W+1:2];
  assign access_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 8'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Access happens on the WAIT->RESP edge; a reset before it drops a store.
          state_d = S_RESP;
          err_d   = access_err;
          if (access_err) begin
            rdata_d = 32'h0;
          end else if (write_q) begin
            rdata_d = 32'h0;
            mem_we  = 1'b1;
          end else begin
            rdata_d = mem[word_idx];
          end
        end
      end
      S_RESP: begin
        // No request is taken on the handshake edge; IDLE must be visited first.
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= wdata_q;
    end
  end

  // Pure state decodes: no combinational path from any input.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
// Responses are scored against queues filled at request acceptance from a word model.
// Timing, backpressure, error and reset behaviour are checked directly around the traffic.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;

  logic clk;
  logic rst_n;
  int   cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_if b2 ();
  data_mem_if b0 ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b2)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {err, rdata} expected per response, in issue order.
  logic [32:0] sb2[$];
  logic [32:0] sb0[$];
  logic [31:0] model2 [int];
  logic [31:0] model0 [int];
  logic [32:0] e2;
  logic [32:0] e0;
  int          acc2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  // Scoreboards: a response is consumed on any cycle with valid and ready both high.
  always @(negedge clk) begin
    if (rst_n && b2.resp_valid && b2.resp_ready) begin
      check("sb2_pending", 32'(sb2.size() != 0), 32'd1);
      if (sb2.size() != 0) begin
        e2 = sb2.pop_front();
        check("resp2_rdata", b2.resp_rdata, e2[31:0]);
        check("resp2_err", 32'(b2.resp_err), 32'(e2[32]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b0.resp_valid && b0.resp_ready) begin
      check("sb0_pending", 32'(sb0.size() != 0), 32'd1);
      if (sb0.size() != 0) begin
        e0 = sb0.pop_front();
        check("resp0_rdata", b0.resp_rdata, e0[31:0]);
        check("resp0_err", 32'(b0.resp_err), 32'(e0[32]));
      end
    end
  end

  // Tasks below start and end one time unit after a rising edge.
  task automatic issue2(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    b2.req_valid = 1'b1;
    b2.req_write = w;
    b2.req_addr  = a;
    b2.req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!b2.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept2", 32'(b2.req_ready), 32'd1);
    @(posedge clk);
    #1;
    acc2 = cyc;
    // Scramble inputs after acceptance: the in-flight access must not see them.
    b2.req_valid = 1'b0;
    b2.req_write = ~w;
    b2.req_addr  = 32'h0000_0004;
    b2.req_wdata = 32'h5A5A_5A5A;
    if (bad_addr(a)) begin
      sb2.push_back({1'b1, 32'h0});
    end else if (w) begin
      model2[int'(a[31:2])] = d;
      sb2.push_back({1'b0, 32'h0});
    end else begin
      sb2.push_back({1'b0, model2[int'(a[31:2])]});
    end
  endtask

  task automatic wait_resp2(input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!b2.resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resp2_latency", cyc - acc2, exp_lat);
  endtask

  task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d);
    issue2(w, a, d);
    wait_resp2(3);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("resp2_one_cycle", 32'(b2.resp_valid), 32'd0);
    check("idle2_ready", 32'(b2.req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // WAIT_CYCLES=0: req_valid held high across three requests to words 0,1,2.
  task automatic run0(input logic w, input logic [31:0] dbase);
    int k;
    int r;
    int acc[4];
    logic take;
    logic [31:0] a;
    k = 0;
    r = 0;
    acc = '{default: 0};
    b0.req_valid = 1'b1;
    b0.req_write = w;
    b0.req_addr  = 32'h0;
    b0.req_wdata = dbase;
    for (int c = 0; c < 40 && r < 3; c++) begin
      @(negedge clk);
      if (b0.resp_valid) begin
        check("lat0", cyc - acc[r], 1);
        r++;
      end
      take = b0.req_ready && b0.req_valid;
      if (take) begin
        acc[k] = cyc + 1;
        if (k > 0) check("spacing0", acc[k] - acc[k-1], 3);
        a = b0.req_addr;
        if (w) begin
          model0[int'(a[31:2])] = b0.req_wdata;
          sb0.push_back({1'b0, 32'h0});
        end else begin
          sb0.push_back({1'b0, model0[int'(a[31:2])]});
        end
      end
      @(posedge clk);
      #1;
      if (take) begin
        k++;
        if (k == 3) begin
          b0.req_valid = 1'b0;
        end else begin
          b0.req_addr  = 32'(k * 4);
          b0.req_wdata = dbase + 32'(k);
        end
      end
    end
    check("count0", r, 3);
    b0.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    b2.resp_ready = 1'b1;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b0.resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst2_req_ready", 32'(b2.req_ready), 32'd1);
    check("rst2_resp_valid", 32'(b2.resp_valid), 32'd0);
    check("rst2_rdata", b2.resp_rdata, 32'h0);
    check("rst2_err", 32'(b2.resp_err), 32'd0);
    check("rst0_req_ready", 32'(b0.req_ready), 32'd1);
    check("rst0_resp_valid", 32'(b0.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store then load at the same word, plus a known value in word 0.
    txn2(1'b1, 32'h0000_0000, 32'h1111_0000);
    txn2(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    txn2(1'b0, 32'h0000_0010, 32'h0);

    // Error cases: none of them may disturb word 0.
    txn2(1'b0, 32'h0000_0012, 32'h0);
    txn2(1'b1, 32'h0000_0400, 32'hBAD0_0001);
    txn2(1'b1, 32'h0000_0002, 32'hBAD0_0002);
    txn2(1'b0, 32'h0000_0400, 32'h0);
    txn2(1'b0, 32'h0000_0000, 32'h0);
    txn2(1'b0, 32'h0000_03FC, 32'h0);
    txn2(1'b1, 32'h0000_03FC, 32'hCAFE_F00D);
    txn2(1'b0, 32'h0000_03FC, 32'h0);

    // Response backpressure with a competing request held on the bus.
    b2.resp_ready = 1'b0;
    issue2(1'b0, 32'h0000_0010, 32'h0);
    wait_resp2(3);
    @(posedge clk);
    #1;
    b2.req_valid = 1'b1;
    b2.req_write = 1'b0;
    b2.req_addr  = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(b2.resp_valid), 32'd1);
      check("bp_rdata", b2.resp_rdata, 32'hDEAD_BEEF);
      check("bp_err", 32'(b2.resp_err), 32'd0);
      check("bp_req_ready", 32'(b2.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    b2.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_req_ready", 32'(b2.req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_no_accept_in_hs", 32'(b2.req_ready), 32'd1);
    @(posedge clk);
    #1;
    acc2 = cyc;
    b2.req_valid = 1'b0;
    sb2.push_back({1'b0, model2[0]});
    wait_resp2(3);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_after_one_cycle", 32'(b2.resp_valid), 32'd0);
    @(posedge clk);
    #1;

    // Zero-wait instance: back-to-back stores, then read them back.
    run0(1'b1, 32'hA000_0000);
    run0(1'b0, 32'h0);

    // Reset while a store sits in WAIT with one count left.
    txn2(1'b1, 32'h0000_0020, 32'hAAAA_AAAA);
    txn2(1'b0, 32'h0000_0010, 32'h0);
    issue2(1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(b2.req_ready), 32'd1);
    check("midrst_resp_valid", 32'(b2.resp_valid), 32'd0);
    check("midrst_rdata", b2.resp_rdata, 32'h0);
    check("midrst_err", 32'(b2.resp_err), 32'd0);
    sb2.delete();
    model2[8] = 32'hAAAA_AAAA;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn2(1'b0, 32'h0000_0020, 32'h0);
    txn2(1'b0, 32'h0000_0010, 32'h0);

    check("sb2_drained", sb2.size(), 0);
    check("sb0_drained", sb0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU's data-memory load/store port. It accepts one word request at a time through a valid/ready request handshake and models a configurable access latency. It returns read data or a write acknowledgement through a valid/ready response handshake. It replaces the zero-latency data memory when the processor moves to a stalling, handshaked memory interface, and it serves as the bus-side model for verifying that initiator.

## Interface
- DEPTH_WORDS, 256 — number of 32-bit words stored; valid word index 0..DEPTH_WORDS-1
- WAIT_CYCLES, 2 — extra wait cycles between request acceptance and data access (0 allowed, max 255)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  initiator presents a request
- req_write  input  1  1 = store word, 0 = load word
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_ready  output  1  responder can accept a request this cycle
- resp_valid  output  1  response available
- resp_ready  input  1  initiator consumes the response
- resp_rdata  output  32  load data; 0 for stores and errors
- resp_err  output  1  request was misaligned or out of range

## Operation
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at the edge: latch write, addr, wdata; load cnt=WAIT_CYCLES; go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt≠0: cnt decrements.
  - If cnt==0: perform the access, register the result into resp_rdata/resp_err, go to RESP.
- Access rules:
  - Word index = addr[31:2].
  - Error when addr[1:0]≠0 or index ≥ DEPTH_WORDS.
  - On error: no array write; resp_rdata=0; resp_err=1.
  - Load: resp_rdata=mem[index]; resp_err=0.
  - Store: mem[index]=wdata at the WAIT→RESP edge; resp_rdata=0; resp_err=0.
- RESP:
  - resp_valid=1, and resp_rdata/resp_err are held stable until handshake.
  - On resp_ready at the edge: go to IDLE.
  - req_valid is ignored in RESP; no request is accepted in the handshake cycle.
- Request inputs are sampled only at the acceptance edge. Later changes do not affect the in-flight access.
- Array contents are not reset and are undefined until written. Reset affects only control and output registers.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0.
- Reset is asynchronous and takes effect immediately, including mid-WAIT or mid-RESP.
  - A store not yet committed (reset before the WAIT→RESP edge) is dropped.
  - A committed store persists.
- Latency: for acceptance at edge E, resp_valid rises after edge E+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives resp_valid one cycle after acceptance.
- With resp_ready held high, resp_valid lasts exactly 1 cycle.
- Minimum request-to-request spacing is WAIT_CYCLES+3 cycles: accept, WAIT_CYCLES+1 wait/access, one RESP cycle, then re-accept from IDLE.
- resp_ready held low stalls in RESP indefinitely; outputs stay constant.
- resp_ready asserted outside RESP has no effect.
- req_ready is a pure decode of state==IDLE and has no combinational path from inputs.

## Test plan
- Reset state, then store and load at the same address:
  - Stimulus: reset, then store 0xDEADBEEF to 0x00000010, then load 0x00000010 with WAIT_CYCLES=2.
  - Required during reset: req_ready=1, resp_valid=0.
  - Required for the load: resp_valid 3 cycles after acceptance, resp_rdata=0xDEADBEEF, resp_err=0.
- Misaligned and out-of-range accesses:
  - Load 0x00000012 → resp_err=1, resp_rdata=0.
  - Store 0x00000400 with DEPTH_WORDS=256 → resp_err=1.
  - A subsequent load of word 0 is unchanged.
- Response backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles in RESP while driving a new req_valid.
  - Required: resp_valid/resp_rdata stable for all 5 cycles, req_ready=0, new request not accepted until after the handshake edge.
- WAIT_CYCLES=0 back-to-back traffic:
  - Stimulus: req_valid held high with stores to 0x0, 0x4, 0x8 and resp_ready=1.
  - Required: each resp_valid pulse exactly one cycle after its acceptance, accepts spaced 3 cycles apart, all three words readable afterward.
- Reset mid-operation:
  - Stimulus: store 0x12345678 to 0x20 on top of prior value 0xAAAAAAAA, assert rst_n=0 during WAIT with cnt=1.
  - Required: outputs return to reset values immediately; a later load of 0x20 returns 0xAAAAAAAA.
